// File: rtl/pixel_fetch_unit_pkg.sv
// Shared types and helpers for the pipe-2 pixel fetch stage.
// Widths, request/response bundles and character byte selection.
package pixel_fetch_unit_pkg;

  localparam int PF_ADDR_W  = 26;
  localparam int PF_DATA_W  = 16;
  localparam int PF_TAG_W   = 8;
  localparam int PF_MAX_OUT = 4;

  typedef enum logic {
    ST_IDLE,
    ST_ISSUE
  } pf_state_e;

  typedef struct packed {
    logic                 is_sprite;
    logic                 char_odd;
    logic [PF_ADDR_W-1:0] base;
    logic [PF_ADDR_W-1:0] offset;
    logic [PF_TAG_W-1:0]  tag;
  } pix_req_t;

  typedef struct packed {
    logic [PF_DATA_W-1:0] data;
    logic [PF_TAG_W-1:0]  tag;
    logic                 is_sprite;
  } pix_rsp_t;

  // Two characters share a word; the odd index lives in the high byte.
  function automatic logic [PF_DATA_W-1:0] char_byte(
    input logic [PF_DATA_W-1:0] w,
    input logic                 odd
  );
    return {8'h00, odd ? w[15:8] : w[7:0]};
  endfunction

endpackage

// File: rtl/pixel_fetch_unit_sync_fifo.sv
// Small synchronous FIFO with a one-cycle synchronous clear.
// Depth must be a power of two; pointers carry one wrap bit.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, rd_q;
  logic         do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push = push_i && !full_o && !clr_i;
  assign do_pop  = pop_i && !empty_o && !clr_i;
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (clr_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/pixel_fetch_unit.sv
// Pipe-2 pixel fetch: issues VRAM word reads and returns
// pixel / character data in order with credit-based flow control.
module pixel_fetch_unit
  import pixel_fetch_unit_pkg::*;
#(
  parameter int ADDR_W  = PF_ADDR_W,
  parameter int DATA_W  = PF_DATA_W,
  parameter int TAG_W   = PF_TAG_W,
  parameter int MAX_OUT = PF_MAX_OUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_sprite,
  input  logic              req_char_odd,
  input  logic [ADDR_W-1:0] req_base_addr,
  input  logic [ADDR_W-1:0] req_addr_offset,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic              flush,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [DATA_W-1:0] pix_data,
  output logic [TAG_W-1:0]  pix_tag,
  output logic              pix_is_sprite,
  output logic              busy
);

  localparam int CW = $clog2(MAX_OUT) + 1;
  localparam int MW = TAG_W + 2;
  localparam logic [CW-1:0] MAXC = CW'(MAX_OUT);

  pf_state_e     state_q, state_d;
  logic          rdy_q;
  logic [CW-1:0] credits_q, credits_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d, drop_sum;

  logic accept, ack_fire, rv_live, pop;
  logic meta_empty, meta_full, rsp_empty, rsp_full;
  logic [MW-1:0]     meta_rd;
  logic [DATA_W-1:0] rsp_rd;

  pix_req_t req;
  pix_rsp_t rsp;

  assign req = '{is_sprite: req_is_sprite,
                 char_odd:  req_char_odd,
                 base:      req_base_addr,
                 offset:    req_addr_offset,
                 tag:       req_tag};

  assign req_ready = rdy_q && !flush && !meta_full;
  assign accept    = req_valid && req_ready;
  assign ack_fire  = (state_q == ST_ISSUE) && mem_ack;
  assign rv_live   = mem_rvalid && (drop_q == '0);
  assign pix_valid = !rsp_empty && !meta_empty;
  assign pop       = pix_valid && pix_ready;
  assign busy      = (state_q != ST_IDLE) ||
                     (credits_q != '0) || (drop_q != '0);

  // Reads still owed by memory after a flush become beats to discard.
  assign drop_sum = drop_q + inflight_q + CW'(ack_fire);

  always_comb begin
    state_d    = state_q;
    credits_d  = credits_q + CW'(accept) - CW'(pop);
    inflight_d = inflight_q + CW'(ack_fire) - CW'(rv_live);
    drop_d     = drop_q;
    if (mem_rvalid && drop_q != '0) drop_d = drop_q - 1'b1;
    if (accept)   state_d = ST_ISSUE;
    if (ack_fire) state_d = ST_IDLE;
    if (flush) begin
      state_d    = ST_IDLE;
      credits_d  = '0;
      inflight_d = '0;
      drop_d     = (mem_rvalid && drop_sum != '0) ?
                   drop_sum - 1'b1 : drop_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rdy_q      <= 1'b0;
      credits_q  <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      mem_rd_req <= 1'b0;
      mem_addr   <= '0;
    end else begin
      state_q    <= state_d;
      credits_q  <= credits_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      rdy_q      <= (state_d == ST_IDLE) &&
                    (credits_d < MAXC) && (drop_d == '0);
      if (flush) begin
        mem_rd_req <= 1'b0;
      end else if (accept) begin
        mem_rd_req <= 1'b1;
        mem_addr   <= req.base + req.offset;
      end else if (ack_fire) begin
        mem_rd_req <= 1'b0;
      end
    end
  end

  sync_fifo #(.W(MW), .DEPTH(MAX_OUT)) u_meta (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clr_i   (flush),
    .push_i  (accept),
    .pop_i   (pop),
    .wdata_i ({req.tag, req.is_sprite, req.char_odd}),
    .rdata_o (meta_rd),
    .empty_o (meta_empty),
    .full_o  (meta_full)
  );

  sync_fifo #(.W(DATA_W), .DEPTH(MAX_OUT)) u_rsp (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clr_i   (flush),
    .push_i  (rv_live && !rsp_full),
    .pop_i   (pop),
    .wdata_i (mem_rdata),
    .rdata_o (rsp_rd),
    .empty_o (rsp_empty),
    .full_o  (rsp_full)
  );

  always_comb begin
    rsp = '0;
    if (pix_valid) begin
      rsp.tag       = meta_rd[MW-1:2];
      rsp.is_sprite = meta_rd[1];
      rsp.data      = meta_rd[1] ? rsp_rd
                                 : char_byte(rsp_rd, meta_rd[0]);
    end
  end

  assign pix_data      = rsp.data;
  assign pix_tag       = rsp.tag;
  assign pix_is_sprite = rsp.is_sprite;

endmodule

// File: tb/tb_pixel_fetch_unit.sv
// Directed bench for pixel_fetch_unit with hand-computed
// expected addresses, data, tags and flow-control behaviour.
module tb_pixel_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_sprite;
  logic        req_char_odd;
  logic [25:0] req_base_addr;
  logic [25:0] req_addr_offset;
  logic [7:0]  req_tag;
  logic        flush;
  logic        mem_rd_req;
  logic [25:0] mem_addr;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        pix_valid;
  logic        pix_ready;
  logic [15:0] pix_data;
  logic [7:0]  pix_tag;
  logic        pix_is_sprite;
  logic        busy;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pixel_fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_is_sprite   (req_is_sprite),
    .req_char_odd    (req_char_odd),
    .req_base_addr   (req_base_addr),
    .req_addr_offset (req_addr_offset),
    .req_tag         (req_tag),
    .flush           (flush),
    .mem_rd_req      (mem_rd_req),
    .mem_addr        (mem_addr),
    .mem_ack         (mem_ack),
    .mem_rvalid      (mem_rvalid),
    .mem_rdata       (mem_rdata),
    .pix_valid       (pix_valid),
    .pix_ready       (pix_ready),
    .pix_data        (pix_data),
    .pix_tag         (pix_tag),
    .pix_is_sprite   (pix_is_sprite),
    .busy            (busy)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_req(input logic [25:0] base,
                           input logic [25:0] off,
                           input logic sp, input logic odd,
                           input logic [7:0] tag,
                           input logic [25:0] exp_addr);
    int n;
    req_valid = 1'b1;
    req_base_addr = base;
    req_addr_offset = off;
    req_is_sprite = sp;
    req_char_odd = odd;
    req_tag = tag;
    n = 0;
    while (!req_ready && n < 8) begin
      tick();
      n++;
    end
    check("req_ready_wait", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    check("rd_req", mem_rd_req, 1'b1);
    check("mem_addr", mem_addr, exp_addr);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
  endtask

  task automatic beat(input logic [15:0] d);
    mem_rvalid = 1'b1;
    mem_rdata = d;
    tick();
    mem_rvalid = 1'b0;
  endtask

  task automatic pop_chk(input logic [15:0] d,
                         input logic [7:0] tag,
                         input logic sp);
    int n;
    n = 0;
    while (!pix_valid && n < 8) begin
      tick();
      n++;
    end
    check("pix_valid", pix_valid, 1'b1);
    check("pix_data", pix_data, d);
    check("pix_tag", pix_tag, tag);
    check("pix_sprite", pix_is_sprite, sp);
    pix_ready = 1'b1;
    tick();
    pix_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc;
    logic acc;
    rst_n = 1'b0;
    req_valid = 0; req_is_sprite = 0; req_char_odd = 0;
    req_base_addr = '0; req_addr_offset = '0; req_tag = '0;
    flush = 0; mem_ack = 0; mem_rvalid = 0; mem_rdata = '0;
    pix_ready = 0;
    repeat (3) tick();
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_rd_req", mem_rd_req, 1'b0);
    check("rst_mem_addr", mem_addr, 26'h0);
    check("rst_pix_valid", pix_valid, 1'b0);
    check("rst_pix_data", pix_data, 16'h0);
    check("rst_pix_tag", pix_tag, 8'h0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick();
    check("ready_after_rst", req_ready, 1'b1);

    // sprite single read
    issue_req(26'h000100, 26'h00002A, 1'b1, 1'b0, 8'd5, 26'h00012A);
    check("ack_drops_req", mem_rd_req, 1'b0);
    tick();
    tick();
    check("no_early_valid", pix_valid, 1'b0);
    beat(16'hBEEF);
    pop_chk(16'hBEEF, 8'd5, 1'b1);
    check("idle_busy", busy, 1'b0);

    // character byte select
    issue_req(26'h0, 26'h10, 1'b0, 1'b0, 8'd6, 26'h10);
    beat(16'h4142);
    pop_chk(16'h0042, 8'd6, 1'b0);
    issue_req(26'h0, 26'h10, 1'b0, 1'b1, 8'd7, 26'h10);
    beat(16'h4142);
    pop_chk(16'h0041, 8'd7, 1'b0);

    // address wrap
    issue_req(26'h3FFFFFF, 26'h2, 1'b1, 1'b0, 8'd8, 26'h1);
    beat(16'h1234);
    pop_chk(16'h1234, 8'd8, 1'b1);

    // backpressure: 6 offered back-to-back, credits cap at 4
    mem_ack = 1'b1;
    req_valid = 1'b1;
    req_is_sprite = 1'b1;
    req_char_odd = 1'b0;
    req_base_addr = 26'h200;
    n_acc = 0;
    for (int c = 0; c < 16; c++) begin
      req_tag = 8'(10 + n_acc);
      req_addr_offset = 26'(n_acc);
      acc = req_valid && req_ready;
      tick();
      if (acc) n_acc++;
      if (n_acc == 6) req_valid = 1'b0;
    end
    check("bp_accepted", n_acc, 4);
    check("bp_ready_low", req_ready, 1'b0);
    req_valid = 1'b0;
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) beat(16'(16'h1000 + i));
    check("bp_still_low", req_ready, 1'b0);
    pop_chk(16'h1000, 8'd10, 1'b1);
    check("bp_ready_after_pop", req_ready, 1'b1);
    issue_req(26'h200, 26'h4, 1'b1, 1'b0, 8'd14, 26'h204);
    beat(16'h1004);
    for (int i = 1; i < 5; i++)
      pop_chk(16'(16'h1000 + i), 8'(10 + i), 1'b1);
    check("bp_busy_done", busy, 1'b0);

    // flush with 3 in flight
    for (int i = 0; i < 3; i++)
      issue_req(26'h300, 26'(i), 1'b1, 1'b0, 8'(20 + i), 26'(26'h300 + i));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_pix_valid", pix_valid, 1'b0);
    check("fl_busy", busy, 1'b1);
    check("fl_ready", req_ready, 1'b0);
    beat(16'hAAAA);
    beat(16'hBBBB);
    check("fl_busy_2", busy, 1'b1);
    check("fl_pv_2", pix_valid, 1'b0);
    beat(16'hCCCC);
    check("fl_busy_3", busy, 1'b0);
    check("fl_pv_3", pix_valid, 1'b0);
    check("fl_ready_back", req_ready, 1'b1);

    // async reset while in ISSUE with a buffered response
    issue_req(26'h40, 26'h1, 1'b1, 1'b0, 8'd30, 26'h41);
    beat(16'h5555);
    req_valid = 1'b1;
    req_tag = 8'd31;
    tick();
    req_valid = 1'b0;
    check("ar_pre_rd_req", mem_rd_req, 1'b1);
    check("ar_pre_pv", pix_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_rd_req", mem_rd_req, 1'b0);
    check("ar_pix_valid", pix_valid, 1'b0);
    check("ar_busy", busy, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
